// File: rtl/mips_reg_file.sv
// 32 x DATA_W register file for a single-cycle MIPS datapath: two combinational
// read ports (RS -> srcl, RT -> RTdata), one rising-edge write port, r0 hardwired to zero.
module mips_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RSaddr,
  input  logic [ADDR_W-1:0] RTaddr,
  input  logic [ADDR_W-1:0] RDaddr,
  input  logic [DATA_W-1:0] RDdata,
  output logic [DATA_W-1:0] RTdata,
  output logic [DATA_W-1:0] srcl,
  input  logic              rst
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  wr_en;

  // One-hot write decode; slot 0 never enables, so r0 stays at its reset value.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_dec
      if (gi == 0) begin : g_zero
        assign wr_en[gi] = 1'b0;
      end else begin : g_reg
        assign wr_en[gi] = RegWrite && (RDaddr == ADDR_W'(gi));
      end
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = wr_en[i] ? RDdata : regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Address 0 is forced to zero in the mux so r0 reads 0 even before the first reset.
  always_comb begin
    srcl   = (RSaddr == '0) ? '0 : regs_q[RSaddr];
    RTdata = (RTaddr == '0) ? '0 : regs_q[RTaddr];
  end

endmodule

// File: tb/tb_mips_reg_file.sv
// Scoreboard bench for mips_reg_file: stimulus pushes expected read-port values,
// a separate monitor pops and compares them against srcl / RTdata.
module tb_mips_reg_file;

  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  RSaddr;
  logic [4:0]  RTaddr;
  logic [4:0]  RDaddr;
  logic [31:0] RDdata;
  logic [31:0] RTdata;
  logic [31:0] srcl;

  mips_reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .RegWrite (RegWrite),
    .RSaddr   (RSaddr),
    .RTaddr   (RTaddr),
    .RDaddr   (RDaddr),
    .RDdata   (RDdata),
    .RTdata   (RTdata),
    .srcl     (srcl),
    .rst      (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] exp_s;
    logic [31:0] exp_t;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  event  chk_ev;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Monitor: the bench raises chk_ev once read ports are settled.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (srcl !== e.exp_s) begin
          n_bad++;
          $display("FAIL %s srcl: RSaddr=%0d got %h expected %h", nm, RSaddr, srcl, e.exp_s);
        end else
          $display("ok   %s srcl: RSaddr=%0d = %h", nm, RSaddr, srcl);
        n_cmp++;
        if (RTdata !== e.exp_t) begin
          n_bad++;
          $display("FAIL %s RTdata: RTaddr=%0d got %h expected %h", nm, RTaddr, RTdata, e.exp_t);
        end else
          $display("ok   %s RTdata: RTaddr=%0d = %h", nm, RTaddr, RTdata);
      end
    end
  end

  task automatic expect_rd(input string nm, input logic [31:0] s, input logic [31:0] t);
    exp_t e;
    #1;
    e.exp_s = s;
    e.exp_t = t;
    exp_q.push_back(e);
    name_q.push_back(nm);
    -> chk_ev;
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    RegWrite = 1'b1;
    RDaddr   = a;
    RDdata   = d;
    @(negedge clk);
    RegWrite = 1'b0;
  endtask

  initial begin
    rst = 1'b1; RegWrite = 1'b0;
    RSaddr = '0; RTaddr = '0; RDaddr = '0; RDdata = '0;
    #12 rst = 1'b0;

    // Reset sweep: every register reads 0 on both ports.
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      RSaddr = 5'(a);
      RTaddr = 5'(31 - a);
      expect_rd("rst_sweep", 32'h0, 32'h0);
    end

    // Fill r0..r31 with i*10 (r0 write must be dropped).
    for (int i = 0; i < 32; i++) write_reg(5'(i), 32'(i * 10));
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      RSaddr = 5'(a);
      RTaddr = 5'd31;
      expect_rd("readback", 32'(a * 10), 32'd310);
    end

    // Write disabled for three edges: r5 keeps 50.
    @(negedge clk);
    RegWrite = 1'b0; RDaddr = 5'd5; RDdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    RSaddr = 5'd5; RTaddr = 5'd5;
    expect_rd("wr_disable", 32'd50, 32'd50);

    // Collision on r7: old value before the edge, new value after, no bypass.
    @(negedge clk);
    RSaddr = 5'd7; RTaddr = 5'd7;
    RDaddr = 5'd7; RDdata = 32'h1234; RegWrite = 1'b1;
    expect_rd("collide_pre", 32'd70, 32'd70);
    @(posedge clk);
    expect_rd("collide_post", 32'h1234, 32'h1234);
    @(negedge clk);
    RegWrite = 1'b0;

    // Zero register ignores writes; neighbour r1 untouched.
    write_reg(5'd0, 32'hFFFF_FFFF);
    RSaddr = 5'd0; RTaddr = 5'd0;
    expect_rd("zero_reg", 32'h0, 32'h0);
    RTaddr = 5'd1;
    expect_rd("zero_nbr", 32'h0, 32'd10);

    // Asynchronous reset mid-cycle, write during reset ignored.
    @(negedge clk);
    RSaddr = 5'd31; RTaddr = 5'd20;
    expect_rd("pre_areset", 32'd310, 32'd200);
    @(posedge clk);
    #3 rst = 1'b1;
    expect_rd("areset_now", 32'h0, 32'h0);
    RegWrite = 1'b1; RDaddr = 5'd31; RDdata = 32'hAAAA_5555;
    @(posedge clk);
    expect_rd("areset_wr", 32'h0, 32'h0);
    @(negedge clk);
    RegWrite = 1'b0;
    rst = 1'b0;
    expect_rd("post_release", 32'h0, 32'h0);

    // First write after release lands on the next edge.
    write_reg(5'd9, 32'd99);
    RSaddr = 5'd9; RTaddr = 5'd31;
    expect_rd("first_wr", 32'd99, 32'h0);

    #5;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
